// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory controller.
// IMEM_PARITY_EN (when defined) adds a stored even-parity bit per word.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_CLEAR
  } imem_state_e;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int WAIT_CNT_W     = 4;
  localparam int PAR_MAX_W      = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage with one synchronous write port and one registered read port.
// IMEM_PARITY_EN (when defined) widens each word by a parity bit checked on read.
module imem_array
  import imem_pkg::*;
#(
  parameter int    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef IMEM_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wr_word;
  logic [SW-1:0] rd_d, rd_q;

  always_comb begin
`ifdef IMEM_PARITY_EN
    wr_word = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
`else
    wr_word = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Read register only moves on rd_en so the response stays stable while stalled.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) rd_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q[DATA_WIDTH-1:0];

`ifdef IMEM_PARITY_EN
  assign rd_perr = rd_q[SW-1] ^ even_parity(PAR_MAX_W'(rd_q[DATA_WIDTH-1:0]));
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory front end: valid/ready fetch port, wait states, load port, clear sequencer.
// IMEM_PARITY_EN (when defined) enables resp_perr from stored word parity.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_perr,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  clr,
  output logic                  clr_busy
);

  localparam logic [WAIT_CNT_W-1:0] WS        = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  imem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clr_pend_q, clr_pend_d;

  logic                  clr_req, blocked, start, rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // A clr pulse counts as pending in its own cycle so it beats a same-cycle request.
  assign clr_req = clr && (state_q != ST_CLEAR);
  assign blocked = clr_pend_q || clr_req;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q || clr_req;
    req_ready  = 1'b0;
    start      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (blocked) state_d = ST_CLEAR;
        else begin
          req_ready = 1'b1;
          start     = req_valid;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_RESP;
          rd_en   = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          if (blocked) state_d = ST_CLEAR;
          else begin
            req_ready = 1'b1;
            start     = req_valid;
            if (!req_valid) state_d = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_pend_d = 1'b0;
        end
      end
    endcase

    if (start) begin
      addr_d = req_addr;
      if (WAIT_STATES == 0) begin
        state_d = ST_RESP;
        rd_en   = 1'b1;
        rd_addr = req_addr;
      end else begin
        state_d = ST_WAIT;
        wait_d  = WS - WAIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      clr_addr_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // The clear sequencer owns the write port; loads are dropped meanwhile.
  assign wr_en   = (state_q == ST_CLEAR) || ld_en;
  assign wr_addr = (state_q == ST_CLEAR) ? clr_addr_q : ld_addr;
  assign wr_data = (state_q == ST_CLEAR) ? '0 : ld_data;

  assign resp_valid = (state_q == ST_RESP);
  assign clr_busy   = (state_q == ST_CLEAR);

  imem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .rst    (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(resp_data),
    .rd_perr(resp_perr)
  );

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: two instances (0 and 2 wait states) checked against a word-array model.
// IMEM_PARITY_EN (when defined) adds a stored-bit corruption step.
module tb_imem_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [2];
  logic          req_valid  [2];
  logic          req_ready  [2];
  logic [AW-1:0] req_addr   [2];
  logic          resp_valid [2];
  logic          resp_ready [2];
  logic [DW-1:0] resp_data  [2];
  logic          resp_perr  [2];
  logic          ld_en      [2];
  logic [AW-1:0] ld_addr    [2];
  logic [DW-1:0] ld_data    [2];
  logic          clr        [2];
  logic          clr_busy   [2];

  imem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_perr(resp_perr[0]), .ld_en(ld_en[0]),
    .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .clr(clr[0]), .clr_busy(clr_busy[0]));

  imem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_perr(resp_perr[1]), .ld_en(ld_en[1]),
    .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .clr(clr[1]), .clr_busy(clr_busy[1]));

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] mdl [2][DEPTH];

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en[s] = 1'b1; ld_addr[s] = a; ld_data[s] = d;
    @(posedge clk); #1;
    ld_en[s] = 1'b0;
    mdl[s][a] = d;
  endtask

  task automatic fetch(input int s, input logic [AW-1:0] a, input int hold, input logic pe);
    int n;
    logic [DW-1:0] exp;
    n = 0;
    @(negedge clk);
    req_valid[s] = 1'b1; req_addr[s] = a; resp_ready[s] = 1'b0;
    #1;
    while (!req_ready[s] && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chkb("accept_ready", req_ready[s], 1'b1);
    exp = mdl[s][a];
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    for (int i = 0; i < ws_of(s); i++) begin
      @(negedge clk);
      chkb("wait_valid_low", resp_valid[s], 1'b0);
    end
    @(negedge clk);
    chkb("resp_valid", resp_valid[s], 1'b1);
    chk("resp_data", resp_data[s], exp);
    chkb("resp_perr", resp_perr[s], pe);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chkb("hold_valid", resp_valid[s], 1'b1);
      chk("hold_data", resp_data[s], exp);
    end
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
    @(negedge clk);
    chkb("resp_drop", resp_valid[s], 1'b0);
  endtask

  task automatic stream(input int s);
    int idx, got, cyc;
    logic [AW-1:0] q[$];
    logic [AW-1:0] ea;
    idx = 0; got = 0; cyc = 0;
    resp_ready[s] = 1'b1;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_valid[s]) begin
        if (q.size() == 0) chkb("stream_unexpected", resp_valid[s], 1'b0);
        else begin
          ea = q.pop_front();
          chk("stream_data", resp_data[s], mdl[s][ea]);
        end
        got++;
      end
      if (idx < 8) begin
        req_valid[s] = 1'b1; req_addr[s] = AW'(idx);
      end else req_valid[s] = 1'b0;
      #1;
      if (req_valid[s] && req_ready[s]) begin
        q.push_back(AW'(idx));
        idx++;
      end
    end
    @(posedge clk); #1;
    req_valid[s] = 1'b0; resp_ready[s] = 1'b0;
    chk("stream_count", 32'(got), 32'd8);
    if (s == 0) chk("stream_cycles", 32'(cyc), 32'd9);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req_valid[s] = 1'b0; req_addr[s] = '0; resp_ready[s] = 1'b0;
      ld_en[s] = 1'b0; ld_addr[s] = '0; ld_data[s] = '0; clr[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chkb("rst_resp_valid", resp_valid[s], 1'b0);
      chk("rst_resp_data", resp_data[s], 32'h0);
      chkb("rst_resp_perr", resp_perr[s], 1'b0);
      chkb("rst_clr_busy", clr_busy[s], 1'b0);
      chkb("rst_req_ready", req_ready[s], 1'b1);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < DEPTH; a++) load(s, AW'(a), $urandom | 32'h100);

    load(0, 4'd3, 32'h20080005);
    fetch(0, 4'd3, 3, 1'b0);
    load(1, 4'd3, 32'h20080005);
    fetch(1, 4'd3, 1, 1'b0);

    stream(0);
    stream(1);

    // read-before-write on the cycle the array is read
    load(0, 4'd5, 32'h1);
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 4'd5; resp_ready[0] = 1'b0;
    ld_en[0] = 1'b1; ld_addr[0] = 4'd5; ld_data[0] = 32'hDEADBEEF;
    #1 chkb("rbw_ready", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; ld_en[0] = 1'b0;
    @(negedge clk);
    chkb("rbw_valid", resp_valid[0], 1'b1);
    chk("rbw_old_data", resp_data[0], 32'h1);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    mdl[0][5] = 32'hDEADBEEF;
    fetch(0, 4'd5, 0, 1'b0);

    // clear while a response is in flight
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 4'd3; resp_ready[1] = 1'b0;
    #1 chkb("clr_acc_ready", req_ready[1], 1'b1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    @(negedge clk);
    chkb("clr_wait_valid", resp_valid[1], 1'b0);
    @(negedge clk);
    chkb("clr_resp_valid", resp_valid[1], 1'b1);
    chk("clr_resp_data", resp_data[1], mdl[1][3]);
    req_valid[1] = 1'b1; req_addr[1] = 4'd4; resp_ready[1] = 1'b1;
    #1 chkb("clr_block_ready", req_ready[1], 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0; resp_ready[1] = 1'b0;
    n = 0; k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (!clr_busy[1]) break;
      n++;
      if (n == 3) begin
        ld_en[1] = 1'b1; ld_addr[1] = 4'd9; ld_data[1] = 32'h00001234;
      end else ld_en[1] = 1'b0;
    end
    ld_en[1] = 1'b0;
    chk("clr_busy_cycles", 32'(n), 32'd16);
    for (int a = 0; a < DEPTH; a++) mdl[1][a] = '0;
    for (int a = 0; a < DEPTH; a++) fetch(1, AW'(a), 0, 1'b0);

    // async reset during WAIT
    load(1, 4'd3, 32'hCAFEF00D);
    fetch(1, 4'd3, 0, 1'b0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 4'd3;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chkb("pre_rst_wait_valid", resp_valid[1], 1'b0);
    chk("pre_rst_data", resp_data[1], 32'hCAFEF00D);
    rst[1] = 1'b1;
    #1;
    chk("rst_wait_data", resp_data[1], 32'h0);
    chkb("rst_wait_valid", resp_valid[1], 1'b0);
    chkb("rst_wait_busy", clr_busy[1], 1'b0);
    @(negedge clk);
    rst[1] = 1'b0;
    fetch(1, 4'd3, 0, 1'b0);

    // async reset during CLEAR; clr beats a same-cycle request in IDLE
    @(negedge clk);
    clr[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 4'd2;
    #1 chkb("clr_prio_ready", req_ready[0], 1'b0);
    @(posedge clk); #1;
    clr[0] = 1'b0; req_valid[0] = 1'b0;
    n = 0; k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (!clr_busy[0]) break;
      n++;
      if (n == 6) break;
    end
    chkb("clr_mid_busy", clr_busy[0], 1'b1);
    rst[0] = 1'b1;
    #1;
    chkb("rst_clr_busy_async", clr_busy[0], 1'b0);
    chkb("rst_clr_valid", resp_valid[0], 1'b0);
    chk("rst_clr_data", resp_data[0], 32'h0);
    @(negedge clk);
    rst[0] = 1'b0;
    for (int a = 0; a < 5; a++) mdl[0][a] = '0;
    for (int a = 0; a < DEPTH; a++) fetch(0, AW'(a), 0, 1'b0);

`ifdef IMEM_PARITY_EN
    u_dut0.u_array.mem[7][0] = ~u_dut0.u_array.mem[7][0];
    mdl[0][7][0] = ~mdl[0][7][0];
    fetch(0, 4'd7, 0, 1'b1);
    fetch(0, 4'd6, 0, 1'b0);
    load(0, 4'd7, 32'h0F0F0F0F);
    fetch(0, 4'd7, 0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      int s;
      logic [AW-1:0] a;
      s = int'($urandom_range(0, 1));
      a = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 2) == 0) load(s, a, $urandom);
      else fetch(s, a, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
